// File: rtl/mem_mc_rr.sv
// mem_mc_rr: NUM_CH requesters share one synchronous RAM through a
// round-robin arbiter. Each channel has its own valid/ready request port and
// its own registered read-return slice.
//
// Ports
//   clk, rst : single rising-edge clock, synchronous active-high reset
//   valid    : per-channel request valid
//   ready    : per-channel grant (one-hot or zero, combinational)
//   wr_rd    : per-channel 1 = write, 0 = read
//   addr     : channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata    : channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   prio     : per-channel high-priority flag (only with MEM_MC_PRIO_EN)
//   rdata    : per-channel read return, same packing as wdata
//   rvalid   : one-cycle pulse, rdata slice of that channel is valid
//   err      : one-cycle pulse, the handshaken address was >= DEPTH
//
// Optional feature macro: MEM_MC_PRIO_EN adds the prio input; valid channels
// with prio = 1 are arbitrated ahead of all prio = 0 channels.
//
// Handshake: a transfer happens on a rising clk edge where valid[c] and
// ready[c] are both 1. A master holds valid and payload stable until it sees
// ready; ready depends only on valid (and prio), the pointer and rst.
module mem_mc_rr #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            valid,
  output logic [NUM_CH-1:0]            ready,
  input  logic [NUM_CH-1:0]            wr_rd,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
`ifdef MEM_MC_PRIO_EN
  input  logic [NUM_CH-1:0]            prio,
`endif
  output logic [NUM_CH*DATA_WIDTH-1:0] rdata,
  output logic [NUM_CH-1:0]            rvalid,
  output logic [NUM_CH-1:0]            err
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PW-1:0] LAST_CH = PW'(NUM_CH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_any;
  logic [NUM_CH-1:0]     req;
  logic                  xfer;
  logic                  sel_wr;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Returns {found, index} of the first set request at or after p, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NUM_CH-1:0] r,
                                          input logic [PW-1:0]     p);
    logic [PW:0] res;
    int          c;
    res = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (int'(p) + i) % NUM_CH;
      if (!res[PW] && r[c]) res = {1'b1, c[PW-1:0]};
    end
    return res;
  endfunction

`ifdef MEM_MC_PRIO_EN
  // The high-priority group, when non-empty, hides every low-priority request.
  assign req = (|(valid & prio)) ? (valid & prio) : valid;
`else
  assign req = valid;
`endif

  always_comb begin
    {gnt_any, gnt_idx} = rr_pick(req, ptr);
    ready = '0;
    if (gnt_any && !rst) ready[gnt_idx] = 1'b1;
  end

  // Payload of the granted channel; only meaningful when xfer is high.
  assign xfer      = |ready;
  assign sel_wr    = wr_rd[gnt_idx];
  assign sel_addr  = addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign in_range  = {1'b0, sel_addr} < DEPTH_LIM;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      rvalid <= '0;
      err    <= '0;
      rdata  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rvalid <= '0;
      err    <= '0;
      if (xfer) begin
        ptr          <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
        err[gnt_idx] <= !in_range;
        if (sel_wr) begin
          if (in_range) mem[sel_addr] <= sel_wdata;
        end else begin
          // rdata slice only changes on a completed read and then holds.
          rvalid[gnt_idx] <= 1'b1;
          rdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH] <= in_range ? mem[sel_addr] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_mc_rr.sv
// Bench for mem_mc_rr with NUM_CH = 2, DATA_WIDTH = 16, DEPTH = 20,
// ADDR_WIDTH = 5. Drivers push the expected response of each handshaken
// read or out-of-range access into exp_q; an independent monitor pops and
// compares whenever rvalid or err is presented.
module tb_mem_mc_rr;
  localparam int NC = 2;
  localparam int DW = 16;
  localparam int DP = 20;
  localparam int AW = 5;
  localparam int EW = 3 + 1 + 1 + DW;   // {ch, rvalid_exp, err_exp, data}

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NC-1:0]    valid = '0;
  logic [NC-1:0]    ready;
  logic [NC-1:0]    wr_rd = '0;
  logic [NC*AW-1:0] addr = '0;
  logic [NC*DW-1:0] wdata = '0;
  logic [NC*DW-1:0] rdata;
  logic [NC-1:0]    rvalid;
  logic [NC-1:0]    err;
`ifdef MEM_MC_PRIO_EN
  logic [NC-1:0]    prio = '0;
`endif

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] mdl [DP];

  mem_mc_rr #(.NUM_CH(NC), .DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .wr_rd(wr_rd),
    .addr(addr), .wdata(wdata),
`ifdef MEM_MC_PRIO_EN
    .prio(prio),
`endif
    .rdata(rdata), .rvalid(rvalid), .err(err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reset: ready must stay 0 while rst is high even with valid requests
  task automatic do_reset();
    rst = 1'b1;
    valid = '1;
    @(posedge clk); #1;
    @(negedge clk);
    check(ready == '0, "ready_during_reset", 32'(ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    valid = '0;
    exp_q.delete();
    for (int i = 0; i < DP; i++) mdl[i] = '0;
    @(negedge clk);
    check(rvalid == '0, "rvalid_after_reset", 32'(rvalid), 0);
    check(err == '0, "err_after_reset", 32'(err), 0);
    check(rdata == '0, "rdata_after_reset", 32'(rdata), 0);
    @(posedge clk); #1;
  endtask

  // driver: called and returns just after a rising edge
  task automatic req(input int ch, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit exp_rv, input bit exp_err,
                     input logic [DW-1:0] exp_d, input int max_wait);
    int waited;
    waited = 0;
    valid[ch] = 1'b1;
    wr_rd[ch] = wr;
    addr[ch*AW +: AW] = a;
    wdata[ch*DW +: DW] = d;
    @(negedge clk);
    while (!ready[ch] && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!ready[ch]) begin
      check(1'b0, $sformatf("grant_timeout_ch%0d", ch), 32'(waited), 32'(max_wait));
    end else begin
      check(waited <= max_wait, $sformatf("wait_ch%0d", ch), 32'(waited), 32'(max_wait));
      if (exp_rv || exp_err) exp_q.push_back({3'(ch), exp_rv, exp_err, exp_d});
    end
    @(posedge clk); #1;
    valid[ch] = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [2:0]    ch;
    logic [NC-1:0] one;
    logic [NC-1:0] exp_rv_v;
    logic [NC-1:0] exp_err_v;
    if (!rst && (|rvalid || |err)) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_response", 32'({rvalid, err}), 0);
      end else begin
        e = exp_q.pop_front();
        ch = e[EW-1 -: 3];
        one = 1;
        exp_rv_v  = e[DW+1] ? (one << ch) : '0;
        exp_err_v = e[DW]   ? (one << ch) : '0;
        check(rvalid == exp_rv_v, $sformatf("rvalid_ch%0d", ch), 32'(rvalid), 32'(exp_rv_v));
        check(err == exp_err_v, $sformatf("err_ch%0d", ch), 32'(err), 32'(exp_err_v));
        if (e[DW+1])
          check(rdata[ch*DW +: DW] == e[DW-1:0], $sformatf("rdata_ch%0d", ch),
                32'(rdata[ch*DW +: DW]), 32'(e[DW-1:0]));
      end
    end
  end

  initial begin
    do_reset();

    // single-channel write then read
    req(0, 1'b1, 5'd3, 16'hA5A5, 1'b0, 1'b0, 16'h0, 0);
    mdl[3] = 16'hA5A5;
    req(0, 1'b0, 5'd3, 16'h0, 1'b1, 1'b0, 16'hA5A5, 0);

    // preload; last writer is ch1 so the pointer returns to 0
    req(0, 1'b1, 5'd0, 16'h0011, 1'b0, 1'b0, 16'h0, 0);
    mdl[0] = 16'h0011;
    req(1, 1'b1, 5'd1, 16'h0022, 1'b0, 1'b0, 16'h0, 0);
    mdl[1] = 16'h0022;

    // contention: grants must alternate ch0, ch1, ...
    fork
      for (int k = 0; k < 3; k++) req(0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b0, 16'h0011, 1);
      for (int k = 0; k < 3; k++) req(1, 1'b0, 5'd1, 16'h0, 1'b1, 1'b0, 16'h0022, 1);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check(ready == ((k % 2 == 0) ? 2'b01 : 2'b10), $sformatf("grant_seq_%0d", k),
              32'(ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      end
    join

    // write on ch1 then read of the same address on ch0 the next cycle
    req(1, 1'b1, 5'd7, 16'h1234, 1'b0, 1'b0, 16'h0, 0);
    mdl[7] = 16'h1234;
    req(0, 1'b0, 5'd7, 16'h0, 1'b1, 1'b0, 16'h1234, 0);

    // out-of-range write and read, then sweep of every valid word
    req(0, 1'b1, 5'd25, 16'hFFFF, 1'b0, 1'b1, 16'h0, 0);
    req(0, 1'b0, 5'd25, 16'h0, 1'b1, 1'b1, 16'h0, 0);
    for (int a = 0; a < DP; a++) req(0, 1'b0, 5'(a), 16'h0, 1'b1, 1'b0, mdl[a], 0);

    // reset in the cycle after a read transfer
    req(0, 1'b1, 5'd9, 16'h5555, 1'b0, 1'b0, 16'h0, 0);
    req(0, 1'b0, 5'd9, 16'h0, 1'b1, 1'b0, 16'h5555, 0);
    do_reset();
    fork
      req(0, 1'b0, 5'd9, 16'h0, 1'b1, 1'b0, 16'h0, 1);
      req(1, 1'b0, 5'd3, 16'h0, 1'b1, 1'b0, 16'h0, 1);
      begin
        @(negedge clk);
        check(ready == 2'b01, "ptr_zero_after_reset", 32'(ready), 32'h1);
      end
    join

`ifdef MEM_MC_PRIO_EN
    do_reset();
    prio = 2'b10;
    fork
      req(0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b0, 16'h0, 1);
      req(1, 1'b0, 5'd1, 16'h0, 1'b1, 1'b0, 16'h0, 0);
      begin
        @(negedge clk);
        check(ready == 2'b10, "prio_first", 32'(ready), 32'h2);
        @(negedge clk);
        check(ready == 2'b01, "prio_second", 32'(ready), 32'h1);
      end
    join
    prio = '0;
`endif

    repeat (3) @(posedge clk);
    check(exp_q.size() == 0, "responses_outstanding", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
